// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default bit timing and ASCII-hex bounds
package uart_pkg;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_t;
  localparam int DEF_CLKS_PER_BIT = 20;
  localparam logic [7:0] CHR_0 = 8'h30;
  localparam logic [7:0] CHR_9 = 8'h39;
  localparam logic [7:0] CHR_UA = 8'h41;
  localparam logic [7:0] CHR_UF = 8'h46;
  localparam logic [7:0] CHR_LA = 8'h61;
  localparam logic [7:0] CHR_LF = 8'h66;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an idle-high asynchronous line
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (reset) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1-style UART receiver with registered ASCII-hex decode
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic RX,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic rx_valid,
  output logic [3:0] hex_nibble,
  output logic hex_ok,
  output logic frame_err,
  output logic busy
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);
  rx_state_t state, state_n;
  logic rxs;
  logic [TW-1:0] timer, timer_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] sh;
  logic [1:0] primed;
  logic take_bit, load, ferr;
  logic [7:0] c;
  logic is_dig, is_up, is_lo, ok;
  logic [3:0] nib;
  sync2 u_sync (.clk(clk), .reset(reset), .d(RX), .q(rxs));
  assign busy = state != IDLE;
  // The synchronizer's reset 1s are not a real idle line: leave WAIT_IDLE only once RX has propagated through.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n = idx;
    take_bit = 1'b0;
    load = 1'b0;
    ferr = 1'b0;
    case (state)
      WAIT_IDLE: state_n = primed[1] && rxs ? IDLE : WAIT_IDLE;
      IDLE: begin
        state_n = rxs ? IDLE : START;
        timer_n = '0;
      end
      START:
        if (timer == T_HALF) begin
          state_n = rxs ? IDLE : DATA;
          timer_n = '0;
        end else timer_n = timer + 1'b1;
      DATA:
        if (timer == T_FULL) begin
          take_bit = 1'b1;
          timer_n = '0;
          idx_n = idx == I_LAST ? '0 : idx + 1'b1;
          state_n = idx == I_LAST ? STOP : DATA;
        end else timer_n = timer + 1'b1;
      STOP:
        if (timer == T_FULL) begin
          timer_n = '0;
          load = rxs;
          ferr = !rxs;
          state_n = rxs ? IDLE : WAIT_IDLE;
        end else timer_n = timer + 1'b1;
      default: state_n = WAIT_IDLE;
    endcase
  end
  always_comb begin
    c = 8'(sh);
    is_dig = c >= CHR_0 && c <= CHR_9;
    is_up = c >= CHR_UA && c <= CHR_UF;
    is_lo = c >= CHR_LA && c <= CHR_LF;
    ok = (sh >> 8) == '0 && (is_dig || is_up || is_lo);
    nib = !ok ? 4'd0 : is_dig ? 4'(c - CHR_0) : is_up ? 4'(c - CHR_UA + 8'd10) : 4'(c - CHR_LA + 8'd10);
  end
  always_ff @(posedge clk)
    if (reset) state <= WAIT_IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      timer <= '0;
      idx <= '0;
      sh <= '0;
      primed <= '0;
      rx_data <= '0;
      hex_nibble <= '0;
      hex_ok <= 1'b0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      timer <= timer_n;
      idx <= idx_n;
      primed <= {primed[0], 1'b1};
      rx_valid <= load;
      frame_err <= ferr;
      if (take_bit) sh[idx] <= rxs;
      if (load) begin
        rx_data <= sh;
        hex_nibble <= nib;
        hex_ok <= ok;
      end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: scoreboard bench driving serial frames into uart_rx_deser
module tb_uart_rx_deser;
  localparam int CPB = 20;
  typedef struct {
    bit v;
    logic [7:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic RX = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, hex_ok, frame_err, busy;
  logic [3:0] hex_nibble;
  int vectors = 0;
  int miscompares = 0;
  int errs = 0;
  longint cyc = 0;
  longint vt[$];
  exp_t q[$];
  logic [7:0] last = 8'h00;
  uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .RX(RX), .rx_data(rx_data), .rx_valid(rx_valid),
    .hex_nibble(hex_nibble), .hex_ok(hex_ok), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] hexm(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39) return {1'b1, 4'(ch - 8'h30)};
    if (ch >= 8'h41 && ch <= 8'h46) return {1'b1, 4'(ch - 8'h41 + 8'd10)};
    if (ch >= 8'h61 && ch <= 8'h66) return {1'b1, 4'(ch - 8'h61 + 8'd10)};
    return 5'd0;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input bit stop_ok);
    q.push_back('{stop_ok, stop_ok ? d : last});
    if (stop_ok) last = d;
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      tick(CPB);
    end
    RX = stop_ok;
    tick(CPB);
  endtask
  always @(negedge clk)
    if (!reset && (rx_valid || frame_err)) begin
      exp_t e;
      logic [4:0] h;
      check("exclusive", 32'(rx_valid & frame_err), 0);
      if (frame_err) errs++;
      if (q.size() == 0) check("unexpected_pulse", 32'({rx_valid, frame_err}), 0);
      else begin
        e = q.pop_front();
        h = hexm(e.d);
        check("kind", 32'(rx_valid), 32'(e.v));
        check("rx_data", 32'(rx_data), 32'(e.d));
        if (e.v) begin
          check("hex_nibble", 32'(hex_nibble), 32'(h[3:0]));
          check("hex_ok", 32'(hex_ok), 32'(h[4]));
          vt.push_back(cyc);
        end
      end
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [7:0] g;
    g = 8'h47;
    tick(4);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_hex_nibble", 32'(hex_nibble), 0);
    check("rst_hex_ok", 32'(hex_ok), 0);
    check("rst_busy", 32'(busy), 1);
    reset = 1'b0;
    tick(5);
    check("idle_busy", 32'(busy), 0);
    tick(3 * CPB);
    send(8'h46, 1'b1);
    RX = 1'b1;
    tick(3 * CPB);
    check("F_count", 32'(vt.size()), 1);
    send(8'h45, 1'b1);
    send(8'h30, 1'b1);
    RX = 1'b1;
    tick(3 * CPB);
    check("E0_count", 32'(vt.size()), 3);
    if (vt.size() == 3) check("E0_spacing", 32'(vt[2] - vt[1]), 200);
    RX = 1'b0;
    tick(5);
    check("glitch_busy_hi", 32'(busy), 1);
    RX = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      tick(1);
      n++;
    end
    check("glitch_busy_drop", 32'(busy), 0);
    tick(2 * CPB);
    check("glitch_no_valid", 32'(vt.size()), 3);
    send(8'h55, 1'b0);
    tick(40);
    check("ferr_wait_busy", 32'(busy), 1);
    RX = 1'b1;
    tick(3 * CPB);
    send(8'h41, 1'b1);
    RX = 1'b1;
    tick(3 * CPB);
    check("ferr_count", 32'(errs), 1);
    check("A_count", 32'(vt.size()), 4);
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      RX = g[i];
      tick(CPB);
    end
    RX = g[4];
    tick(10);
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    last = 8'h00;
    tick(30);
    check("low_after_rst_busy", 32'(busy), 1);
    check("rst_mid_rx_data", 32'(rx_data), 0);
    RX = 1'b1;
    tick(3 * CPB);
    send(g, 1'b1);
    RX = 1'b1;
    tick(3 * CPB);
    check("G_count", 32'(vt.size()), 5);
    check("G_hold_data", 32'(rx_data), 32'h47);
    check("G_hold_ok", 32'(hex_ok), 0);
    check("ferr_total", 32'(errs), 1);
    check("drain", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
